// File: rtl/vga_pic_pkg.sv
// Shared definitions for the VGA picture generator: RGB565 colours, mode
// encodings, the window configuration record and the colour-bar palette.
package vga_pic_pkg;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] PURPLE = 16'hF81F;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] GRAY   = 16'hD69A;

  localparam int PAL_N = 10;

  typedef enum logic [1:0] {
    MODE_BARS        = 2'd0,
    MODE_BARS_SPRITE = 2'd1,
    MODE_SOLID       = 2'd2,
    MODE_GRID        = 2'd3
  } mode_e;

  // Field order matches the rx byte order, so the 8 bytes pack straight in.
  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] w;
    logic [15:0] y0;
    logic [15:0] h;
  } win_cfg_t;

  function automatic logic [15:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return RED;
      4'd1:    return ORANGE;
      4'd2:    return YELLOW;
      4'd3:    return GREEN;
      4'd4:    return CYAN;
      4'd5:    return BLUE;
      4'd6:    return PURPLE;
      4'd7:    return BLACK;
      4'd8:    return WHITE;
      4'd9:    return GRAY;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_cfg_rx.sv
// Window configuration receiver: assembles 8-byte frames, aborts stale partial
// frames on rx silence, and commits the shadow set only at the frame tick.
module vga_cfg_rx
  import vga_pic_pkg::*;
#(
  parameter int TIMEOUT = 250000
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  input  logic       ftick,
  output win_cfg_t   active,
  output logic       win_en,
  output logic       frame_err
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [2:0]       idx;
  logic [7:0]       rx_buf [8];
  win_cfg_t         shadow;
  logic             pend;
  logic [CNT_W-1:0] gap_cnt;
  win_cfg_t         active_next;

  assign active_next = pend ? shadow : active;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx       <= '0;
      shadow    <= '0;
      active    <= '0;
      pend      <= 1'b0;
      win_en    <= 1'b0;
      frame_err <= 1'b0;
      gap_cnt   <= '0;
      // NOTE: the byte buffer is only eight flops, so it is reset like any
      // other register; large RAM arrays would normally be left unreset.
      for (int i = 0; i < 8; i++) rx_buf[i] <= '0;
    end else begin
      frame_err <= 1'b0;

      if (ftick) begin
        active <= active_next;
        pend   <= 1'b0;
        win_en <= (active_next != '0);
      end

      if (pi_flag) begin
        gap_cnt     <= '0;
        idx         <= idx + 3'd1;
        rx_buf[idx] <= pi_data;
        // Last byte lands here; a frame completing on the tick stays pending.
        if (idx == 3'd7) begin
          shadow <= {rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3],
                     rx_buf[4], rx_buf[5], rx_buf[6], pi_data};
          pend   <= 1'b1;
        end
      end else if (gap_cnt != CNT_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
        if (gap_cnt == CNT_MAX - 1'b1 && idx != 3'd0) begin
          idx       <= '0;
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pic_win.sv
// VGA picture generator: background by mode, bouncing ROM sprite, and a
// UART-programmed window mask, all behind a fixed 2-cycle pixel pipeline.
module vga_pic_win
  import vga_pic_pkg::*;
#(
  parameter int H_VALID  = 640,
  parameter int V_VALID  = 480,
  parameter int COORD_W  = 10,
  parameter int H_PIC    = 50,
  parameter int W_PIC    = 50,
  parameter int ADDR_W   = 12,
  parameter int STEP     = 1,
  parameter int NUM_BARS = 10,
  parameter int TIMEOUT  = 250000
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic [7:0]         pi_data,
  input  logic               pi_flag,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [1:0]         mode,
  output logic               rom_rden,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [15:0]        rom_data,
  output logic [15:0]        pix_data_out,
  output logic               win_en,
  output logic               frame_err
);

  localparam int                 BAR_W     = H_VALID / NUM_BARS;
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(H_PIC * W_PIC - 1);
  localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(H_VALID - H_PIC);
  localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(V_VALID - W_PIC);
  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
  localparam logic [COORD_W:0]   STEP_EXT  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   HPIC_EXT  = (COORD_W+1)'(H_PIC);
  localparam logic [COORD_W:0]   WPIC_EXT  = (COORD_W+1)'(W_PIC);

  mode_e              mode_q;
  logic               ftick;
  win_cfg_t           active;
  logic [COORD_W-1:0] xm, ym;
  logic               x_neg, y_neg;
  logic               rd_en, win_hit, blank;
  logic [15:0]        bg;
  logic [COORD_W-1:0] bar_q;
  logic [COORD_W:0]   x_end, y_end;
  logic [16:0]        px, py, wx_end, wy_end;
  logic [15:0]        s1_bg;
  logic               s1_sprite, s1_block, s1_blank;

  assign mode_q = mode_e'(mode);
  assign ftick  = (pix_x == COORD_W'(H_VALID - 1)) && (pix_y == COORD_W'(V_VALID - 1));

  vga_cfg_rx #(.TIMEOUT(TIMEOUT)) u_cfg_rx (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .ftick     (ftick),
    .active    (active),
    .win_en    (win_en),
    .frame_err (frame_err)
  );

  // Returns {moving_negative, new_position}; clamps at either wall and turns.
  function automatic logic [COORD_W:0] axis_step(input logic [COORD_W-1:0] pos,
                                                 input logic               neg,
                                                 input logic [COORD_W-1:0] lim);
    logic [COORD_W:0] sum;
    sum = {1'b0, pos} + STEP_EXT;
    if (!neg) return (sum >= {1'b0, lim}) ? {1'b1, lim} : {1'b0, sum[COORD_W-1:0]};
    return (pos <= STEP_C) ? {1'b0, {COORD_W{1'b0}}} : {1'b1, pos - STEP_C};
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    bg     = BLACK;
    bar_q  = pix_x / COORD_W'(BAR_W);
    x_end  = {1'b0, xm} + HPIC_EXT;
    y_end  = {1'b0, ym} + WPIC_EXT;
    px     = 17'(pix_x);
    py     = 17'(pix_y);
    wx_end = {1'b0, active.x0} + {1'b0, active.w};
    wy_end = {1'b0, active.y0} + {1'b0, active.h};

    case (mode_q)
      MODE_BARS, MODE_BARS_SPRITE: bg = bar_color(4'(bar_q % COORD_W'(PAL_N)));
      MODE_SOLID:                  bg = GRAY;
      MODE_GRID:                   bg = (pix_x[4:0] == 5'd0 || pix_y[4:0] == 5'd0) ? WHITE : BLACK;
      default:                     bg = BLACK;
    endcase

    rd_en   = (mode_q == MODE_BARS_SPRITE) &&
              (pix_x >= xm) && ({1'b0, pix_x} < x_end) &&
              (pix_y >= ym) && ({1'b0, pix_y} < y_end);
    win_hit = (px >= {1'b0, active.x0}) && (px < wx_end) &&
              (py >= {1'b0, active.y0}) && (py < wy_end);
    blank   = (pix_x >= COORD_W'(H_VALID)) || (pix_y >= COORD_W'(V_VALID));
  end

  // Held low during reset so every output reads 0 while sys_rst_n is asserted.
  assign rom_rden = rd_en & sys_rst_n;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      xm       <= '0;
      ym       <= '0;
      x_neg    <= 1'b0;
      y_neg    <= 1'b0;
      rom_addr <= '0;
    end else if (ftick) begin
      rom_addr       <= '0;
      {x_neg, xm}    <= axis_step(xm, x_neg, X_LIM);
      {y_neg, ym}    <= axis_step(ym, y_neg, Y_LIM);
    end else if (rd_en) begin
      rom_addr <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + 1'b1;
    end
  end

  // The mask decision is taken in S1 against the same window state as win_hit,
  // so the pixel carrying the frame tick is judged consistently.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_bg        <= '0;
      s1_sprite    <= 1'b0;
      s1_block     <= 1'b0;
      s1_blank     <= 1'b0;
      pix_data_out <= '0;
    end else begin
      s1_bg     <= bg;
      s1_sprite <= rd_en;
      s1_block  <= win_en && !win_hit;
      s1_blank  <= blank;

      if (s1_blank || s1_block) pix_data_out <= BLACK;
      else if (s1_sprite)       pix_data_out <= rom_data;
      else                      pix_data_out <= s1_bg;
    end
  end

endmodule

// File: tb/tb_vga_pic_win.sv
// Scoreboard bench for vga_pic_win: the driver queues hand-derived expectations
// stamped with the cycle they are due; a negedge monitor pops and compares.
module tb_vga_pic_win;

  localparam int H_VALID = 640;
  localparam int V_VALID = 480;
  localparam int COORD_W = 10;
  localparam int H_PIC   = 50;
  localparam int W_PIC   = 50;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 300;

  localparam logic [15:0] C_RED    = 16'hF800;
  localparam logic [15:0] C_ORANGE = 16'hFC00;
  localparam logic [15:0] C_GREEN  = 16'h07E0;
  localparam logic [15:0] C_CYAN   = 16'h07FF;
  localparam logic [15:0] C_WHITE  = 16'hFFFF;
  localparam logic [15:0] C_GRAY   = 16'hD69A;
  localparam logic [15:0] C_BLACK  = 16'h0000;

  logic               vga_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [7:0]         pi_data = '0;
  logic               pi_flag = 1'b0;
  logic [COORD_W-1:0] pix_x = '0;
  logic [COORD_W-1:0] pix_y = '0;
  logic [1:0]         mode = 2'd1;
  logic               rom_rden;
  logic [ADDR_W-1:0]  rom_addr;
  logic [15:0]        rom_data = '0;
  logic [15:0]        pix_data_out;
  logic               win_en;
  logic               frame_err;

  vga_pic_win #(
    .H_VALID(H_VALID), .V_VALID(V_VALID), .COORD_W(COORD_W), .H_PIC(H_PIC),
    .W_PIC(W_PIC), .ADDR_W(ADDR_W), .STEP(1), .NUM_BARS(10), .TIMEOUT(TIMEOUT)
  ) dut (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .pi_data      (pi_data),
    .pi_flag      (pi_flag),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .mode         (mode),
    .rom_rden     (rom_rden),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pix_data_out (pix_data_out),
    .win_en       (win_en),
    .frame_err    (frame_err)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM model: 1-cycle latency, content tags the address so sprite pixels are traceable.
  always @(posedge vga_clk) if (rom_rden) rom_data <= 16'hA000 | 16'(rom_addr);

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef enum {K_PIX, K_RDEN, K_ADDR, K_WIN, K_ERR} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] pal [10] = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
                            16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A};

  function automatic logic [15:0] actual(input kind_e k);
    case (k)
      K_PIX:   return pix_data_out;
      K_RDEN:  return 16'(rom_rden);
      K_ADDR:  return 16'(rom_addr);
      K_WIN:   return 16'(win_en);
      default: return 16'(frame_err);
    endcase
  endfunction

  always @(negedge vga_clk) begin
    int i;
    logic [15:0] act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        act = actual(q[i].kind);
        checks++;
        if (q[i].due != cyc || act !== q[i].exp) begin
          errors++;
          $display("FAIL %s: got %h, required %h (cycle %0d, due %0d)",
                   q[i].name, act, q[i].exp, cyc, q[i].due);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(input int due, input kind_e k, input logic [15:0] e, input string n);
    q.push_back('{due, k, e, n});
  endtask

  task automatic drv(input int x, input int y, input bit flag = 1'b0, input logic [7:0] b = 8'h00);
    pix_x   = COORD_W'(x);
    pix_y   = COORD_W'(y);
    pi_flag = flag;
    pi_data = b;
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [15:0] e, input string n);
    drv(x, y);
    expect_at(cyc + 2, K_PIX, e, n);
    step();
  endtask

  task automatic rden_chk(input int x, input int y, input logic e, input string n);
    drv(x, y);
    expect_at(cyc, K_RDEN, 16'(e), n);
    step();
  endtask

  task automatic rx_send(input logic [7:0] b);
    drv(H_VALID + 20, 10, 1'b1, b);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drv(H_VALID + 20, V_VALID + 5);
      step();
    end
  endtask

  task automatic frame_tick();
    drv(H_VALID - 1, V_VALID - 1);
    step();
  endtask

  task automatic outputs_zero(input string tag);
    expect_at(cyc, K_PIX,  16'h0, {tag, "_pix"});
    expect_at(cyc, K_RDEN, 16'h0, {tag, "_rden"});
    expect_at(cyc, K_ADDR, 16'h0, {tag, "_addr"});
    expect_at(cyc, K_WIN,  16'h0, {tag, "_win"});
    expect_at(cyc, K_ERR,  16'h0, {tag, "_err"});
  endtask

  typedef struct { int x; int y; logic [15:0] e; } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t win_vecs[$];
    vec_t win2_vecs[$];
    int   c_last;

    // Reset state: mode 1 with coordinates inside the home sprite.
    drv(25, 25);
    step();
    outputs_zero("reset");
    step();

    mode      = 2'd0;
    sys_rst_n = 1'b1;

    // One active line of bars, then blanking.
    for (int x = 0; x < H_VALID; x++) begin
      if (x < 64)        pix(x, 0, C_RED,  "bar_red");
      else if (x >= 576) pix(x, 0, C_GRAY, "bar_gray");
      else               pix(x, 0, pal[x / 64], "bar_mid");
    end
    pix(640, 0, C_BLACK, "hblank_640");
    pix(700, 0, C_BLACK, "hblank_700");
    pix(0, 480, C_BLACK, "vblank_480");

    // Solid and grid modes; a mode change applies on the next pixel.
    mode = 2'd2;
    pix(5, 5, C_GRAY, "solid");
    mode = 2'd3;
    pix(32, 7,  C_WHITE, "grid_col");
    pix(33, 7,  C_BLACK, "grid_off");
    pix(33, 64, C_WHITE, "grid_row");
    mode = 2'd0;
    pix(33, 7,  C_RED,   "back_to_bars");

    // Window frame X0=100 W=200 Y0=50 H=100, sent mid-frame: no effect before the tick.
    begin
      logic [7:0] f1 [8] = '{8'h00, 8'h64, 8'h00, 8'hC8, 8'h00, 8'h32, 8'h00, 8'h64};
      for (int i = 0; i < 8; i++) begin
        drv(100 + i, 200, 1'b1, f1[i]);
        expect_at(cyc + 2, K_PIX, C_ORANGE, "pre_tick_bars");
        step();
      end
    end
    drv(150, 100);
    expect_at(cyc, K_WIN, 16'h0, "pre_tick_win_en");
    expect_at(cyc + 2, K_PIX, 16'hFFE0, "pre_tick_inside");
    step();
    pix(10, 10, C_RED, "pre_tick_outside");

    drv(H_VALID - 1, V_VALID - 1);
    expect_at(cyc + 1, K_WIN, 16'h1, "win_en_after_tick");
    step();

    win_vecs = '{'{99, 50, C_BLACK}, '{100, 50, C_ORANGE}, '{299, 149, C_CYAN},
                 '{300, 149, C_BLACK}, '{100, 49, C_BLACK}, '{100, 150, C_BLACK},
                 '{200, 100, C_GREEN}, '{0, 0, C_BLACK}, '{700, 100, C_BLACK},
                 '{299, 50, C_CYAN}, '{639, 479, C_BLACK}};
    foreach (win_vecs[i]) pix(win_vecs[i].x, win_vecs[i].y, win_vecs[i].e, "window_1");

    // Partial frame then silence: one frame_err pulse, parser back to byte 0.
    idle(3);
    rx_send(8'h01);
    rx_send(8'h02);
    drv(H_VALID + 20, 10, 1'b1, 8'h03);
    c_last = cyc;
    expect_at(c_last + TIMEOUT,     K_ERR, 16'h0, "timeout_early");
    expect_at(c_last + TIMEOUT + 1, K_ERR, 16'h1, "timeout_pulse");
    expect_at(c_last + TIMEOUT + 2, K_ERR, 16'h0, "timeout_one_cycle");
    step();
    idle(TIMEOUT + 5);

    // Following frame X0=10 W=20 Y0=5 H=10 must be accepted intact.
    begin
      logic [7:0] f2 [8] = '{8'h00, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h05, 8'h00, 8'h0A};
      for (int i = 0; i < 8; i++) rx_send(f2[i]);
    end
    frame_tick();
    win2_vecs = '{'{10, 5, C_RED}, '{29, 14, C_RED}, '{30, 14, C_BLACK},
                  '{9, 5, C_BLACK}, '{10, 15, C_BLACK}, '{10, 4, C_BLACK},
                  '{29, 5, C_RED}, '{150, 100, C_BLACK}};
    foreach (win2_vecs[i]) pix(win2_vecs[i].x, win2_vecs[i].y, win2_vecs[i].e, "window_2");
    drv(20, 10);
    expect_at(cyc, K_WIN, 16'h1, "win_en_frame_2");
    step();

    // Reset mid-line and mid-rx-frame, with the sprite under the current pixel.
    mode = 2'd1;
    idle(3);
    rx_send(8'hAA);
    rx_send(8'hBB);
    rx_send(8'hCC);
    drv(25, 25);
    #2;
    sys_rst_n = 1'b0;
    outputs_zero("mid_reset");
    step();
    step();
    sys_rst_n = 1'b1;

    // Sprite at (0,0): ROM walks 0..2499 over the first 50 lines.
    for (int y = 0; y < W_PIC; y++) begin
      for (int x = 0; x < 60; x++) begin
        int a;
        a = (y * H_PIC + ((x < H_PIC) ? x : H_PIC)) % (H_PIC * W_PIC);
        drv(x, y);
        expect_at(cyc, K_ADDR, 16'(a), "sprite_addr");
        expect_at(cyc, K_RDEN, (x < H_PIC) ? 16'h1 : 16'h0, "sprite_rden");
        expect_at(cyc + 2, K_PIX, (x < H_PIC) ? (16'hA000 | 16'(a)) : C_RED, "sprite_pix");
        step();
      end
    end
    drv(0, 50);
    expect_at(cyc, K_ADDR, 16'h0, "addr_wrapped");
    expect_at(cyc, K_RDEN, 16'h0, "below_sprite_rden");
    expect_at(cyc, K_WIN,  16'h0, "post_reset_win_en");
    expect_at(cyc + 2, K_PIX, C_RED, "below_sprite_pix");
    step();

    // All-zero frame keeps the mask off; partial pre-reset bytes must not shift it.
    for (int i = 0; i < 8; i++) rx_send(8'h00);
    drv(H_VALID - 1, V_VALID - 1);
    expect_at(cyc + 1, K_WIN, 16'h0, "zero_frame_win_en");
    step();
    pix(1, 0, C_RED, "sprite11_above");
    pix(0, 1, C_RED, "sprite11_left");
    drv(1, 1);
    expect_at(cyc, K_ADDR, 16'h0, "addr_after_tick");
    expect_at(cyc, K_RDEN, 16'h1, "sprite11_rden");
    expect_at(cyc + 2, K_PIX, 16'hA000, "sprite11_pix");
    step();

    // Bounce: sprite is at (1,1) after one tick.
    for (int t = 2; t <= 591; t++) begin
      frame_tick();
      if (t == 430) begin
        rden_chk(430, 430, 1'b1, "y_at_430");
        rden_chk(429, 430, 1'b0, "y_at_430_left");
        rden_chk(430, 429, 1'b0, "y_at_430_above");
        rden_chk(479, 479, 1'b1, "y_at_430_corner");
      end
      if (t == 431) begin
        rden_chk(431, 429, 1'b1, "y_rev_429");
        rden_chk(431, 428, 1'b0, "y_rev_above");
        rden_chk(480, 478, 1'b1, "y_rev_corner");
        rden_chk(480, 479, 1'b0, "y_rev_below");
      end
      if (t == 590) begin
        rden_chk(590, 270, 1'b1, "x_at_590");
        rden_chk(589, 270, 1'b0, "x_at_590_left");
        rden_chk(590, 269, 1'b0, "x_at_590_above");
        rden_chk(639, 319, 1'b1, "x_at_590_corner");
        rden_chk(639, 320, 1'b0, "x_at_590_below");
      end
      if (t == 591) begin
        rden_chk(589, 269, 1'b1, "x_rev_589");
        rden_chk(588, 269, 1'b0, "x_rev_left");
        rden_chk(638, 318, 1'b1, "x_rev_corner");
        rden_chk(639, 318, 1'b0, "x_rev_right");
      end
    end

    idle(4);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations never compared, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
